// File: rtl/melody_sequencer.sv
// melody_sequencer: turns coin and dispense events into a four-step timed
// melody code for the piezo tone generator. It holds one pending request so
// that an event arriving mid-melody is kept, and the newest such event wins.
module melody_sequencer #(
  parameter int NOTE_CYCLES = 250000,
  parameter int GAP_CYCLES  = 50000,
  parameter int CNT_W       = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_100,
  input  logic       coin_500,
  input  logic       coin_1000,
  input  logic       prod_buy,
  input  logic [1:0] prod_id,
  input  logic       mute,
  output logic [3:0] note_state,
  output logic [2:0] note_played,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       step_q, step_d;
  logic [3:0]       code_q, code_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pend_vld_q, pend_vld_d;
  logic [3:0]       pend_code_q, pend_code_d;

  logic             req_vld;
  logic [3:0]       req_code;
  logic             next_vld;   // pending after this cycle's request lands
  logic [3:0]       next_code;

  // Same-cycle priority: product > 1000 > 500 > 100; the losers are dropped.
  always_comb begin
    req_vld  = prod_buy | coin_1000 | coin_500 | coin_100;
    req_code = 4'd0;
    if (prod_buy)       req_code = {2'b01, prod_id};
    else if (coin_1000) req_code = 4'd3;
    else if (coin_500)  req_code = 4'd2;
    else if (coin_100)  req_code = 4'd1;
    // A request on the final gap cycle must be the one that starts next.
    next_vld  = req_vld | pend_vld_q;
    next_code = req_vld ? req_code : pend_code_q;
  end

  // State, counter and registered outputs; reset wipes everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      step_q      <= 3'd0;
      code_q      <= 4'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_code_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      code_q      <= code_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_vld_q  <= pend_vld_d;
      pend_code_q <= pend_code_d;
    end
  end

  // Next state and duration counter; mute forces IDLE regardless of requests.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mute) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (req_vld) state_d = PLAY;
        end
        PLAY: begin
          if (cnt_q == NOTE_LAST) begin
            cnt_d = '0;
            if (step_q == 3'd4) state_d = GAP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = next_vld ? PLAY : IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Next output values and pending slot, registered alongside the state.
  always_comb begin
    step_d      = step_q;
    code_d      = code_q;
    done_d      = 1'b0;
    busy_d      = (state_d != IDLE);
    pend_vld_d  = pend_vld_q;
    pend_code_d = pend_code_q;
    if (mute) begin
      step_d      = 3'd0;
      code_d      = 4'd0;
      pend_vld_d  = 1'b0;
      pend_code_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_vld) begin
            code_d = req_code;
            step_d = 3'd1;
          end
        end
        PLAY: begin
          // Requests mid-melody only touch the pending slot, never code_q.
          if (req_vld) begin
            pend_vld_d  = 1'b1;
            pend_code_d = req_code;
          end
          if (cnt_q == NOTE_LAST) begin
            if (step_q < 3'd4) begin
              step_d = step_q + 3'd1;
            end else begin
              step_d = 3'd0;
              code_d = 4'd0;
              done_d = 1'b1;
            end
          end
        end
        GAP: begin
          if (req_vld) begin
            pend_vld_d  = 1'b1;
            pend_code_d = req_code;
          end
          if (cnt_q == GAP_LAST && next_vld) begin
            code_d      = next_code;
            step_d      = 3'd1;
            pend_vld_d  = 1'b0;
            pend_code_d = 4'd0;
          end
        end
        default: begin
          step_d = 3'd0;
          code_d = 4'd0;
        end
      endcase
    end
  end

  assign note_state  = code_q;
  assign note_played = step_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
